// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the byte-serial instruction fetcher.
// Holds the FSM state encoding, word/byte widths and the request address helper.
package inst_fetcher_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned INST_W  = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned N_BYTES = INST_W / BYTE_W;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned LOW_W   = INST_W - BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

   // Byte address of request number cnt within the word starting at pc (wraps mod 2^32).
   function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] pc,
                                                  input logic [CNT_W-1:0]  cnt);
      return pc + ADDR_W'(cnt);
   endfunction

endpackage

// File: rtl/inst_fetcher.sv
// Fetches a 32-bit little-endian instruction as four byte reads through a shared
// memory arbiter, then hands it to the decoder with stall/flush handling.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk_in,
   input  logic              rst_in,
   output logic              mem_rd_out,
   output logic [ADDR_W-1:0] mem_a_out,
   input  logic              mem_gnt_in,
   input  logic [BYTE_W-1:0] mem_din_in,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic [ADDR_W-1:0] flush_pc_in,
   output logic              inst_req_out,
   output logic [INST_W-1:0] inst_out,
   output logic [ADDR_W-1:0] pc_out
);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [CNT_W-1:0]  issue_cnt_q;
   logic [CNT_W-1:0]  recv_cnt_q;
   logic              issue_done_q;
   logic              rx_pend_q;
   logic [LOW_W-1:0]  word_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] mem_a_q;
   logic              inst_req_q;
   logic [INST_W-1:0] inst_q;
   logic [ADDR_W-1:0] pc_out_q;

   logic              granted;
   logic [CNT_W-1:0]  issue_cnt_d;
   logic              issue_done_d;
   logic              last_byte;
   logic [INST_W-1:0] word_full;

   // Request bookkeeping; the counter wraps after the 4th grant, so a done flag marks completion.
   always_comb begin
      granted      = mem_rd_q & mem_gnt_in;
      issue_cnt_d  = issue_cnt_q + CNT_W'(granted);
      issue_done_d = issue_done_q | (granted & (issue_cnt_q == CNT_W'(N_BYTES - 1)));
      last_byte    = rx_pend_q & (recv_cnt_q == CNT_W'(N_BYTES - 1));
      word_full    = {mem_din_in, word_q};
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         issue_cnt_q  <= '0;
         recv_cnt_q   <= '0;
         issue_done_q <= 1'b0;
         rx_pend_q    <= 1'b0;
         word_q       <= '0;
         mem_rd_q     <= 1'b0;
         mem_a_q      <= '0;
         inst_req_q   <= 1'b0;
         inst_q       <= '0;
         pc_out_q     <= '0;
      end else begin
         inst_req_q <= 1'b0;
         if (flush_in) begin
            // Redirect wins over everything; clearing rx_pend drops the in-flight byte.
            state_q      <= ST_FETCH;
            pc_q         <= flush_pc_in;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            issue_done_q <= 1'b0;
            rx_pend_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_a_q      <= flush_pc_in;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q  <= ST_FETCH;
                  mem_rd_q <= 1'b0;
               end
               ST_FETCH: begin
                  issue_cnt_q  <= issue_cnt_d;
                  issue_done_q <= issue_done_d;
                  rx_pend_q    <= granted;
                  mem_rd_q     <= ~issue_done_d;
                  mem_a_q      <= byte_addr(pc_q, issue_cnt_d);
                  if (rx_pend_q) begin
                     recv_cnt_q <= recv_cnt_q + CNT_W'(1);
                     case (recv_cnt_q)
                        2'd0:    word_q[7:0]   <= mem_din_in;
                        2'd1:    word_q[15:8]  <= mem_din_in;
                        2'd2:    word_q[23:16] <= mem_din_in;
                        default: ;
                     endcase
                  end
                  if (last_byte) begin
                     inst_q       <= word_full;
                     pc_out_q     <= pc_q;
                     issue_cnt_q  <= '0;
                     recv_cnt_q   <= '0;
                     issue_done_q <= 1'b0;
                     rx_pend_q    <= 1'b0;
                     mem_rd_q     <= 1'b0;
                     if (!stall_in) begin
                        inst_req_q <= 1'b1;
                        pc_q       <= pc_q + ADDR_W'(N_BYTES);
                        mem_a_q    <= pc_q + ADDR_W'(N_BYTES);
                        state_q    <= ST_FETCH;
                     end else begin
                        state_q <= ST_HOLD;
                     end
                  end
               end
               ST_HOLD: begin
                  mem_rd_q <= 1'b0;
                  if (!stall_in) begin
                     inst_req_q <= 1'b1;
                     pc_q       <= pc_q + ADDR_W'(N_BYTES);
                     mem_a_q    <= pc_q + ADDR_W'(N_BYTES);
                     state_q    <= ST_FETCH;
                  end
               end
               default: begin
                  state_q  <= ST_FETCH;
                  mem_rd_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mem_rd_out   = mem_rd_q;
   assign mem_a_out    = mem_a_q;
   assign inst_req_out = inst_req_q;
   assign inst_out     = inst_q;
   assign pc_out       = pc_out_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: a byte memory model answers granted reads,
// a vector table covers fetch patterns, and hand sequences cover stall/flush/reset.
module tb_inst_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd;
   logic [31:0] mem_a;
   logic        gnt;
   logic [7:0]  din;
   logic        stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        inst_req;
   logic [31:0] inst;
   logic [31:0] pc_o;

   int n_cmp = 0;
   int n_bad = 0;

   inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .mem_rd_out  (mem_rd),
      .mem_a_out   (mem_a),
      .mem_gnt_in  (gnt),
      .mem_din_in  (din),
      .stall_in    (stall),
      .flush_in    (flush),
      .flush_pc_in (flush_pc),
      .inst_req_out(inst_req),
      .inst_out    (inst),
      .pc_out      (pc_o)
   );

   always #5 clk = ~clk;

   // Memory image: 13 05 00 00 at address 0, elsewhere byte = addr[7:0] + 0x11.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h05;
         32'd2:   return 8'h00;
         32'd3:   return 8'h00;
         default: return lo + 8'h11;
      endcase
   endfunction

   // Data is returned one cycle after each granted request; junk otherwise.
   always @(posedge clk) begin
      if (mem_rd && gnt) din <= mem_byte(mem_a);
      else               din <= 8'hEE;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush    = 1'b1;
      flush_pc = pc;
      cycle();
      flush    = 1'b0;
   endtask

   task automatic wait_rd(input string nm);
      for (int i = 0; i < 20; i++) begin
         if (mem_rd) break;
         cycle();
      end
      chk({nm, "_rd"}, 32'(mem_rd), 32'd1);
   endtask

   // Drives grants from mask (bit i = i-th request cycle), measures latency from first grant.
   task automatic run_fetch(input string nm, input logic [7:0] mask, input logic [31:0] exp_inst,
                            input logic [31:0] exp_pc, input logic [31:0] exp_next, input int exp_lat);
      int idx;
      int c0;
      int n;
      idx = 0;
      c0  = -1;
      for (n = 0; n < 40; n++) begin
         if (inst_req) break;
         if (mem_rd) begin
            gnt = (idx < 8) ? mask[idx[2:0]] : 1'b1;
            if (gnt && c0 < 0) c0 = n;
            idx++;
         end else begin
            gnt = 1'b1;
         end
         cycle();
      end
      gnt = 1'b1;
      chk({nm, "_pulse"}, 32'(inst_req), 32'd1);
      if (inst_req) begin
         chk({nm, "_lat"}, 32'(n - c0), 32'(exp_lat));
         chk({nm, "_inst"}, inst, exp_inst);
         chk({nm, "_pc"}, pc_o, exp_pc);
         cycle();
         chk({nm, "_single"}, 32'(inst_req), 32'd0);
         chk({nm, "_next_rd"}, 32'(mem_rd), 32'd1);
         chk({nm, "_next_a"}, mem_a, exp_next);
      end
   endtask

   typedef struct {
      logic [31:0] start_pc;
      logic [7:0]  gmask;
      logic [31:0] exp_inst;
      logic [31:0] exp_next;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n;
      vecs[0] = '{32'h0000_0004, 8'hFF,        32'h1817_1615, 32'h0000_0008, 5};
      vecs[1] = '{32'h0000_0001, 8'hFF,        32'h1500_0005, 32'h0000_0005, 5};
      vecs[2] = '{32'h0000_0000, 8'b1111_1001, 32'h0000_0513, 32'h0000_0004, 7};
      vecs[3] = '{32'h0000_0100, 8'b1111_1110, 32'h1413_1211, 32'h0000_0104, 5};
      vecs[4] = '{32'h0000_002A, 8'b1101_0101, 32'h3E3D_3C3B, 32'h0000_002E, 8};
      vecs[5] = '{32'hFFFF_FFFC, 8'hFF,        32'h100F_0E0D, 32'h0000_0000, 5};

      rst = 1'b1; gnt = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0;
      cycle();
      cycle();
      chk("rst_rd", 32'(mem_rd), 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_req", 32'(inst_req), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      rst = 1'b0;
      cycle();
      chk("first_rd", 32'(mem_rd), 32'd1);
      chk("first_a", mem_a, 32'd0);
      run_fetch("first", 8'hFF, 32'h0000_0513, 32'd0, 32'd4, 5);

      // Grant withheld on 2nd and 3rd request: address must hold at pc+1.
      do_flush(32'd0);
      wait_rd("hold");
      chk("hold_a0", mem_a, 32'd0);
      gnt = 1'b1; cycle();
      chk("hold_a1", mem_a, 32'd1);
      gnt = 1'b0; cycle();
      chk("hold_a2", mem_a, 32'd1);
      gnt = 1'b0; cycle();
      chk("hold_a3", mem_a, 32'd1);
      gnt = 1'b1;
      for (n = 0; n < 20; n++) begin
         if (inst_req) break;
         cycle();
      end
      chk("hold_lat", 32'(n + 3), 32'd7);
      chk("hold_inst", inst, 32'h0000_0513);

      for (int i = 0; i < 6; i++) begin
         do_flush(vecs[i].start_pc);
         run_fetch($sformatf("vec%0d", i), vecs[i].gmask, vecs[i].exp_inst,
                   vecs[i].start_pc, vecs[i].exp_next, vecs[i].exp_lat);
      end

      // Stall at completion for three cycles, then release.
      do_flush(32'd0);
      stall = 1'b1;
      wait_rd("stall");
      gnt = 1'b1;
      repeat (5) cycle();
      for (int k = 0; k < 3; k++) begin
         chk("stall_noreq", 32'(inst_req), 32'd0);
         chk("stall_inst", inst, 32'h0000_0513);
         chk("stall_rd", 32'(mem_rd), 32'd0);
         if (k == 2) stall = 1'b0;
         cycle();
      end
      chk("stall_pulse", 32'(inst_req), 32'd1);
      chk("stall_inst_rel", inst, 32'h0000_0513);
      chk("stall_pc", pc_o, 32'd0);
      cycle();
      chk("stall_single", 32'(inst_req), 32'd0);
      chk("stall_next_rd", 32'(mem_rd), 32'd1);
      chk("stall_next_a", mem_a, 32'd4);

      // Flush after two bytes; the byte granted in the flush cycle must be dropped.
      do_flush(32'd0);
      wait_rd("fl");
      gnt = 1'b1;
      cycle();
      cycle();
      flush = 1'b1; flush_pc = 32'h100;
      cycle();
      flush = 1'b0;
      chk("fl_noreq", 32'(inst_req), 32'd0);
      chk("fl_rd_off", 32'(mem_rd), 32'd0);
      cycle();
      chk("fl_rd", 32'(mem_rd), 32'd1);
      chk("fl_a", mem_a, 32'h100);
      run_fetch("fl_new", 8'hFF, 32'h1413_1211, 32'h100, 32'h104, 5);

      // Flush in the same cycle the last byte arrives suppresses the pulse.
      do_flush(32'd4);
      wait_rd("flc");
      gnt = 1'b1;
      repeat (4) cycle();
      flush = 1'b1; flush_pc = 32'h200;
      cycle();
      flush = 1'b0;
      chk("flc_noreq", 32'(inst_req), 32'd0);
      cycle();
      chk("flc_rd", 32'(mem_rd), 32'd1);
      chk("flc_a", mem_a, 32'h200);

      // Reset while holding a stalled word.
      do_flush(32'd4);
      stall = 1'b1;
      wait_rd("rh");
      gnt = 1'b1;
      repeat (5) cycle();
      chk("rh_held_inst", inst, 32'h1817_1615);
      chk("rh_held_req", 32'(inst_req), 32'd0);
      rst = 1'b1;
      cycle();
      chk("rh_rd", 32'(mem_rd), 32'd0);
      chk("rh_a", mem_a, 32'd0);
      chk("rh_req", 32'(inst_req), 32'd0);
      chk("rh_inst", inst, 32'd0);
      chk("rh_pc", pc_o, 32'd0);
      rst = 1'b0;
      stall = 1'b0;
      cycle();
      chk("rh_restart_rd", 32'(mem_rd), 32'd1);
      chk("rh_restart_a", mem_a, 32'd0);
      run_fetch("rh_fetch", 8'hFF, 32'h0000_0513, 32'd0, 32'd4, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
